// File: rtl/regfile_sload.sv
//==============================================================================
// Module      : regfile_sload
// Description : RISC-V style integer register file with two combinational read
//               ports, one direct write port and a lane-serial load engine.
//               Register x0 is hardwired to zero.
//               Optional feature macro: REGFILE_BYPASS_EN. When it is defined,
//               same-cycle write/commit data is forwarded to the read ports.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module regfile_sload #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 16,
    parameter int LANE_W = 8,
    parameter int SEL_W  = $clog2(NREGS),
    parameter int NLANES = XLEN / LANE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [SEL_W-1:0]  rs1_sel,
    input  logic [SEL_W-1:0]  rs2_sel,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              ld_start,
    input  logic [SEL_W-1:0]  ld_sel,
    input  logic              ld_lane_valid,
    input  logic [LANE_W-1:0] ld_lane_data,
    output logic              ld_busy,
    output logic              ld_done
);

    // Lane counter must hold 0..NLANES-1; keep at least one bit for NLANES=1.
    localparam int              CNT_W       = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam logic [CNT_W-1:0] c_LAST_LANE = CNT_W'(NLANES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t              r_state;
    logic [SEL_W-1:0]    r_target;
    logic [XLEN-1:0]     r_buf;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_done;
    logic                r_busy;
    logic [NREGS-1:0]    r_pending;
    logic [XLEN-1:0]     r_regs [NREGS];
    logic                w_commit;

    assign w_commit = (r_state == S_COMMIT);
    assign ld_done  = r_done;
    assign ld_busy  = r_busy;

    // Load engine: latch target, collect lanes LSB-first, then one commit cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_target <= '0;
            r_buf    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (ld_start) begin
                        r_target <= ld_sel;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // No lane timeout: the engine waits indefinitely for data.
                    if (ld_lane_valid) begin
                        r_buf[int'(r_cnt)*LANE_W +: LANE_W] <= ld_lane_data;
                        if (r_cnt == c_LAST_LANE) begin
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                            r_state <= S_COMMIT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Pending flags: set when a load to a nonzero target starts, cleared at commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (r_state == S_IDLE && ld_start && ld_sel != '0) begin
            r_pending[ld_sel] <= 1'b1;
        end else if (w_commit) begin
            r_pending[r_target] <= 1'b0;
        end
    end

    // Register storage: commit has priority over a direct write to the same index.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        if (gi == 0) begin : g_zero
            // x0 is constant zero.
            always_ff @(posedge clk) begin
                r_regs[gi] <= '0;
            end
        end else begin : g_rw
            // Writable register: reset clear, commit first, then direct write.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_regs[gi] <= '0;
                end else if (w_commit && r_target == SEL_W'(gi)) begin
                    r_regs[gi] <= r_buf;
                end else if (wr_en && wr_sel == SEL_W'(gi)) begin
                    r_regs[gi] <= wr_data;
                end
            end
        end
    end

    // Read port value, optionally forwarding same-cycle commit/write data.
    function automatic logic [XLEN-1:0] f_read(input logic [SEL_W-1:0] sel);
        logic [XLEN-1:0] v;
        v = r_regs[sel];
`ifdef REGFILE_BYPASS_EN
        if (w_commit && r_target == sel) begin
            v = r_buf;
        end else if (wr_en && wr_sel == sel) begin
            v = wr_data;
        end
`endif
        if (sel == '0) begin
            v = '0;
        end
        return v;
    endfunction

    // Busy flag of a read port; with forwarding it drops during the commit cycle.
    function automatic logic f_busy(input logic [SEL_W-1:0] sel);
        logic b;
        b = r_pending[sel];
`ifdef REGFILE_BYPASS_EN
        if (w_commit && r_target == sel) begin
            b = 1'b0;
        end
`endif
        return b;
    endfunction

    assign rs1_data = f_read(rs1_sel);
    assign rs2_data = f_read(rs2_sel);
    assign rs1_busy = f_busy(rs1_sel);
    assign rs2_busy = f_busy(rs2_sel);

endmodule

`default_nettype wire

// File: tb/tb_regfile_sload.sv
//==============================================================================
// Module      : tb_regfile_sload
// Description : Randomized and directed bench for regfile_sload against a
//               lane-queue reference model. Honours REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_regfile_sload;

    localparam int c_XLEN  = 32;
    localparam int c_NREGS = 16;
    localparam int c_LW    = 8;
    localparam int c_SW    = 4;
    localparam int c_NL    = c_XLEN / c_LW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [c_SW-1:0]   wr_sel;
    logic [c_XLEN-1:0] wr_data;
    logic [c_SW-1:0]   rs1_sel, rs2_sel;
    logic [c_XLEN-1:0] rs1_data, rs2_data;
    logic              rs1_busy, rs2_busy;
    logic              ld_start;
    logic [c_SW-1:0]   ld_sel;
    logic              ld_lane_valid;
    logic [c_LW-1:0]   ld_lane_data;
    logic              ld_busy, ld_done;

    // Second instance: 32 registers, 4-bit lanes.
    logic        b_rst_n, b_wr_en, b_ld_start, b_lane_valid;
    logic [4:0]  b_wr_sel, b_rs1_sel, b_rs2_sel, b_ld_sel;
    logic [31:0] b_wr_data, b_rs1_data, b_rs2_data;
    logic [3:0]  b_lane_data;
    logic        b_rs1_busy, b_rs2_busy, b_ld_busy, b_ld_done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [c_XLEN-1:0] m_regs [c_NREGS];
    logic [c_NREGS-1:0] m_pend;
    logic              m_active;
    logic [c_SW-1:0]   m_target;
    logic [c_LW-1:0]   m_lanes [$];

    always #5 clk = ~clk;

    regfile_sload u_dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .ld_start(ld_start), .ld_sel(ld_sel),
        .ld_lane_valid(ld_lane_valid), .ld_lane_data(ld_lane_data),
        .ld_busy(ld_busy), .ld_done(ld_done)
    );

    regfile_sload #(.XLEN(32), .NREGS(32), .LANE_W(4)) u_dut32 (
        .clk(clk), .rst_n(b_rst_n),
        .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_data(b_wr_data),
        .rs1_sel(b_rs1_sel), .rs2_sel(b_rs2_sel),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
        .ld_start(b_ld_start), .ld_sel(b_ld_sel),
        .ld_lane_valid(b_lane_valid), .ld_lane_data(b_lane_data),
        .ld_busy(b_ld_busy), .ld_done(b_ld_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_in_commit();
        return m_active && (m_lanes.size() == c_NL);
    endfunction

    // Assembled load value: lane k occupies bits [k*LW +: LW].
    function automatic logic [c_XLEN-1:0] m_load_value();
        logic [c_XLEN-1:0] v = '0;
        for (int k = 0; k < m_lanes.size(); k++)
            v = v | (c_XLEN'(m_lanes[k]) << (k * c_LW));
        return v;
    endfunction

    function automatic logic [c_XLEN-1:0] exp_read(input logic [c_SW-1:0] sel);
        if (sel == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (m_in_commit() && m_target == sel) return m_load_value();
        if (wr_en && wr_sel == sel) return wr_data;
`endif
        return m_regs[sel];
    endfunction

    function automatic logic exp_busy(input logic [c_SW-1:0] sel);
`ifdef REGFILE_BYPASS_EN
        if (m_in_commit() && m_target == sel) return 1'b0;
`endif
        return m_pend[sel];
    endfunction

    // Compare every output of the main DUT against the model mid-cycle.
    task automatic sample();
        @(negedge clk);
        check("rs1_data", rs1_data, exp_read(rs1_sel));
        check("rs2_data", rs2_data, exp_read(rs2_sel));
        check("rs1_busy", rs1_busy, exp_busy(rs1_sel));
        check("rs2_busy", rs2_busy, exp_busy(rs2_sel));
        check("ld_busy", ld_busy, m_active);
        check("ld_done", ld_done, m_in_commit());
    endtask

    // Advance model across the rising edge using the inputs held this cycle.
    task automatic advance();
        logic commit_now;
        @(posedge clk);
        commit_now = m_in_commit();
        if (!rst_n) begin
            for (int i = 0; i < c_NREGS; i++) m_regs[i] = '0;
            m_pend   = '0;
            m_active = 1'b0;
            m_lanes.delete();
        end else begin
            if (wr_en && wr_sel != 0) m_regs[wr_sel] = wr_data;
            if (commit_now) begin
                if (m_target != 0) m_regs[m_target] = m_load_value();
                m_pend[m_target] = 1'b0;
                m_active = 1'b0;
                m_lanes.delete();
            end else if (m_active) begin
                if (ld_lane_valid) m_lanes.push_back(ld_lane_data);
            end else if (ld_start) begin
                m_active = 1'b1;
                m_target = ld_sel;
                m_lanes.delete();
                if (ld_sel != 0) m_pend[ld_sel] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    // Full load with 4 back-to-back lanes and an optional direct write in the commit cycle.
    task automatic run_load(input logic [3:0] sel, input logic [31:0] val,
                            input logic cw, input logic [3:0] cwsel, input logic [31:0] cwdata);
        ld_start = 1'b1; ld_sel = sel;
        cyc();
        ld_start = 1'b0;
        for (int k = 0; k < c_NL; k++) begin
            ld_lane_valid = 1'b1; ld_lane_data = val[k*c_LW +: c_LW];
            cyc();
        end
        ld_lane_valid = 1'b0;
        wr_en = cw; wr_sel = cwsel; wr_data = cwdata;
        sample();
        check("commit_done", ld_done, 1'b1);
        advance();
        wr_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
        rs1_sel = '0; rs2_sel = '0; ld_start = 1'b0; ld_sel = '0;
        ld_lane_valid = 1'b0; ld_lane_data = '0;
        b_rst_n = 1'b0; b_wr_en = 1'b0; b_wr_sel = '0; b_wr_data = '0;
        b_rs1_sel = 5'd31; b_rs2_sel = '0; b_ld_start = 1'b0; b_ld_sel = '0;
        b_lane_valid = 1'b0; b_lane_data = '0;
        for (int i = 0; i < c_NREGS; i++) m_regs[i] = '0;
        m_pend = '0; m_active = 1'b0; m_target = '0;

        // 32-register / 4-bit-lane instance: load x31 with 8 lanes.
        @(posedge clk); #1;
        b_rst_n = 1'b1; b_ld_start = 1'b1; b_ld_sel = 5'd31;
        @(posedge clk); #1;
        b_ld_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            b_lane_valid = 1'b1; b_lane_data = 4'(k + 1);
            @(negedge clk);
            check("b_rs1_busy_shift", b_rs1_busy, 1'b1);
            check("b_ld_busy_shift", b_ld_busy, 1'b1);
            check("b_ld_done_shift", b_ld_done, 1'b0);
            @(posedge clk); #1;
        end
        b_lane_valid = 1'b0;
        @(negedge clk);
        check("b_ld_done_commit", b_ld_done, 1'b1);
`ifdef REGFILE_BYPASS_EN
        check("b_rs1_busy_commit", b_rs1_busy, 1'b0);
        check("b_rs1_data_commit", b_rs1_data, 32'h87654321);
`else
        check("b_rs1_busy_commit", b_rs1_busy, 1'b1);
        check("b_rs1_data_commit", b_rs1_data, 32'h0);
`endif
        @(posedge clk); #1;
        @(negedge clk);
        check("b_ld_done_after", b_ld_done, 1'b0);
        check("b_x31", b_rs1_data, 32'h87654321);
        check("b_rs1_busy_after", b_rs1_busy, 1'b0);
        check("b_ld_busy_after", b_ld_busy, 1'b0);
        @(posedge clk); #1;

        // Main instance: reset state.
        rs1_sel = 4'd5; rs2_sel = 4'd7;
        cyc();
        sample();
        check("reset_ld_busy", ld_busy, 1'b0);
        check("reset_x5", rs1_data, 32'h0);
        advance();
        rst_n = 1'b1;

        // Direct writes, including a discarded write to x0.
        wr_en = 1'b1; wr_sel = 4'd5; wr_data = 32'hDEADBEEF;
        cyc();
        wr_sel = 4'd0; wr_data = 32'h1234;
        sample();
        check("x5_after_write", rs1_data, 32'hDEADBEEF);
        advance();
        wr_en = 1'b0; rs2_sel = 4'd0;
        sample();
        check("x0_zero", rs2_data, 32'h0);
        advance();

        // Serial load to x7 with one idle gap between lanes 2 and 3.
        rs1_sel = 4'd7;
        ld_start = 1'b1; ld_sel = 4'd7;
        cyc();
        ld_start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            ld_lane_valid = (c != 3);
            case (c)
                1: ld_lane_data = 8'h11;
                2: ld_lane_data = 8'h22;
                4: ld_lane_data = 8'h33;
                5: ld_lane_data = 8'h44;
                default: ld_lane_data = 8'hEE;
            endcase
            sample();
            check("x7_busy_shift", rs1_busy, 1'b1);
            check("x7_no_done_shift", ld_done, 1'b0);
            advance();
        end
        ld_lane_valid = 1'b1; ld_lane_data = 8'hFF;
        sample();
        check("x7_done_cycle6", ld_done, 1'b1);
        advance();
        ld_lane_valid = 1'b0;
        sample();
        check("x7_value", rs1_data, 32'h44332211);
        check("x7_done_once", ld_done, 1'b0);
        advance();

        // Commit vs same-register and different-register direct write.
        rs1_sel = 4'd3; rs2_sel = 4'd4;
        run_load(4'd3, 32'hA5A5A5A5, 1'b1, 4'd3, 32'h1);
        sample();
        check("x3_commit_wins", rs1_data, 32'hA5A5A5A5);
        advance();
        run_load(4'd3, 32'hA5A5A5A5, 1'b1, 4'd4, 32'h1);
        sample();
        check("x4_direct", rs2_data, 32'h1);
        check("x3_commit", rs1_data, 32'hA5A5A5A5);
        advance();

        // Reset in the middle of a load to x9.
        rs1_sel = 4'd9;
        ld_start = 1'b1; ld_sel = 4'd9;
        cyc();
        ld_start = 1'b0; ld_lane_valid = 1'b1; ld_lane_data = 8'h55;
        cyc();
        cyc();
        ld_lane_valid = 1'b0; rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            check("rst_x9", rs1_data, 32'h0);
            check("rst_ld_busy", ld_busy, 1'b0);
            check("rst_no_done", ld_done, 1'b0);
            advance();
        end
        ld_start = 1'b1; ld_sel = 4'd9;
        cyc();
        ld_start = 1'b0;
        sample();
        check("restart_busy", ld_busy, 1'b1);
        advance();
        ld_lane_valid = 1'b1;
        for (int k = 0; k < c_NL + 1; k++) begin
            ld_lane_data = 8'(k + 1);
            cyc();
        end
        ld_lane_valid = 1'b0;
        cyc();

        // Same-cycle write/read of x2 (x2 is zero since the reset above).
        wr_en = 1'b1; wr_sel = 4'd2; wr_data = 32'hCAFE; rs2_sel = 4'd2;
        sample();
`ifdef REGFILE_BYPASS_EN
        check("x2_same_cycle", rs2_data, 32'hCAFE);
`else
        check("x2_same_cycle", rs2_data, 32'h0);
`endif
        advance();
        wr_en = 1'b0;
        sample();
        check("x2_next_cycle", rs2_data, 32'hCAFE);
        advance();

        // Randomized traffic, biased toward the load target to exercise collisions.
        for (int n = 0; n < 3000; n++) begin
            rst_n         = ($urandom_range(0, 249) != 0);
            wr_en         = ($urandom_range(0, 2) == 0);
            wr_sel        = ($urandom_range(0, 3) == 0) ? m_target : 4'($urandom_range(0, 15));
            wr_data       = $urandom;
            rs1_sel       = ($urandom_range(0, 1) == 0) ? m_target : 4'($urandom_range(0, 15));
            rs2_sel       = 4'($urandom_range(0, 15));
            ld_start      = ($urandom_range(0, 4) == 0);
            ld_sel        = 4'($urandom_range(0, 15));
            ld_lane_valid = ($urandom_range(0, 2) != 0);
            ld_lane_data  = 8'($urandom_range(0, 255));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_sload.md
REGFILE_SLOAD -- requirements
Module: regfile_sload

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: register width in bits.
REQ-002 The block SHALL have parameter NREGS, default 16: register count; legal values are 16 (RV32E) and 32 (RV32I).
REQ-003 The block SHALL have parameter LANE_W, default 8: serial-load lane width; XLEN SHALL be an integer multiple of LANE_W.
REQ-004 The block SHALL derive SEL_W = clog2(NREGS) and NLANES = XLEN/LANE_W.
REQ-005 The block SHALL have port clk, input, 1: clock, rising-edge.
REQ-006 The block SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 The block SHALL have port wr_en, input, 1: direct write strobe.
REQ-008 The block SHALL have port wr_sel, input, SEL_W: direct write index.
REQ-009 The block SHALL have port wr_data, input, XLEN: direct write value.
REQ-010 The block SHALL have ports rs1_sel/rs2_sel, input, SEL_W: read indices.
REQ-011 The block SHALL have ports rs1_data/rs2_data, output, XLEN: read values, combinational.
REQ-012 The block SHALL have ports rs1_busy/rs2_busy, output, 1: selected register has a serial load pending.
REQ-013 The block SHALL have port ld_start, input, 1: begin a serial load.
REQ-014 The block SHALL have port ld_sel, input, SEL_W: serial load target.
REQ-015 The block SHALL have port ld_lane_valid, input, 1: lane data valid.
REQ-016 The block SHALL have port ld_lane_data, input, LANE_W: lane data.
REQ-017 The block SHALL have port ld_busy, output, 1: load engine not IDLE.
REQ-018 The block SHALL have port ld_done, output, 1: one-cycle commit pulse.

Function
REQ-019 The block SHALL hardwire register 0 to zero: writes and commits to index 0 are discarded, reads return 0, and pending[0] is never set.
REQ-020 The block SHALL apply a direct write (wr_en=1) on the rising edge; the new value is visible on reads from the next cycle.
REQ-021 The load FSM SHALL have three states: IDLE, SHIFT and COMMIT.
REQ-022 In IDLE with ld_start=1, the FSM SHALL latch ld_sel, set pending[ld_sel] (if nonzero), clear the lane counter and go to SHIFT.
REQ-023 ld_start SHALL be ignored outside IDLE.
REQ-024 In SHIFT, each cycle with ld_lane_valid=1 SHALL place ld_lane_data at bits [k*LANE_W +: LANE_W] of the shift buffer (k = lane count, LSB lane first) and increment k.
REQ-025 Cycles without ld_lane_valid SHALL stall with no timeout.
REQ-026 When lane NLANES-1 is accepted, the FSM SHALL go to COMMIT.
REQ-027 ld_lane_valid SHALL be ignored in IDLE and COMMIT.
REQ-028 In COMMIT, the buffer SHALL be written to the target, pending[target] cleared and ld_done=1 for exactly that cycle; the next state is IDLE.
REQ-029 A load SHALL therefore take 1 + NLANES + 1 cycles minimum from ld_start to the return to IDLE.
REQ-030 ld_busy SHALL be 1 in SHIFT and COMMIT.
REQ-031 rsN_busy SHALL equal pending[rsN_sel].
REQ-032 A direct write and a commit to different registers in the same cycle SHALL both take effect.
REQ-033 A direct write and a commit to the same register in the same cycle: the commit value SHALL win.
REQ-034 A direct write to a pending register during SHIFT SHALL take effect and be overwritten at commit; pending stays set.
REQ-035 A load to index 0 SHALL run the full sequence including the ld_done pulse, with no write.

Reset
REQ-036 While rst_n=0 at a clock edge, all registers, all pending bits, the shift buffer and the lane counter SHALL clear, the FSM SHALL go to IDLE, and ld_done and ld_busy SHALL be 0.
REQ-037 Reset mid-load SHALL abort the load with no commit and no ld_done pulse.

Configuration
REQ-038 With macro REGFILE_BYPASS_EN defined, a read whose index matches a same-cycle nonzero direct write or commit target SHALL return that incoming value (commit value when both match), and rsN_busy SHALL read 0 in the commit cycle.
REQ-039 Without REGFILE_BYPASS_EN, reads SHALL return stored values only, and busy SHALL clear the cycle after COMMIT.

Verification
REQ-040 Reset, then wr_en x5=0xDEADBEEF -> rs1_sel=5 reads 0xDEADBEEF next cycle; wr_en x0=0x1234 -> x0 reads 0.
REQ-041 ld_start x7, lanes 0x11,0x22,0x33,0x44 with one idle gap -> x7=0x44332211, rs busy=1 throughout SHIFT, ld_done a single pulse 6 cycles after ld_start.
REQ-042 Commit x3=0xA5A5A5A5 while wr_en x3=0x1 in the same cycle -> x3=0xA5A5A5A5; repeat with wr_en x4=0x1 -> x4=0x1 and x3=0xA5A5A5A5.
REQ-043 rst_n=0 after 2 lanes of a load to x9 holding 0x55 -> x9=0, ld_busy=0, no ld_done; a new ld_start is accepted.
REQ-044 With REGFILE_BYPASS_EN: wr_en x2=0xCAFE and rs2_sel=2 in the same cycle -> rs2_data=0xCAFE that cycle; without the macro -> old value that cycle, 0xCAFE next cycle.
REQ-045 NREGS=32, LANE_W=4: serial load to x31 with 8 lanes -> correct commit; rs1_sel=31 busy during SHIFT.
